// File: rtl/fifo_drain_checker.sv
// rtl/fifo_drain_checker.sv - drains an output FIFO and compares each entry against expected memory
module fifo_drain_checker #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CNT_WIDTH-1:0]       expected_count,
    output logic                       fifo_deq,
    input  logic [DATA_WIDTH-1:0]      fifo_data_out,
    input  logic                       fifo_empty,
    output logic [FIFO_ADDR_WIDTH-1:0] exp_addr,
    input  logic [DATA_WIDTH-1:0]      exp_data,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       count_short,
    output logic [CNT_WIDTH-1:0]       num_read,
    output logic [CNT_WIDTH-1:0]       num_mismatch
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH   = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
    localparam logic [FIFO_ADDR_WIDTH:0] IDX_ONE = (FIFO_ADDR_WIDTH+1)'(1);
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]     CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]               state;
    logic [FIFO_ADDR_WIDTH:0] issue_idx;
    logic                     cmp_valid;
    logic [CNT_WIDTH-1:0]     exp_count_q;
    logic [CNT_WIDTH-1:0]     read_next;
    logic [CNT_WIDTH-1:0]     mismatch_next;

    // Combinational from state so an asynchronous reset drops the strobe at once
    assign fifo_deq = (state == ST_DRAIN) && !fifo_empty && (issue_idx != DEPTH);
    assign exp_addr = issue_idx[FIFO_ADDR_WIDTH-1:0];
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    // Counter values including the compare that completes on this edge
    always_comb begin
        read_next     = num_read;
        mismatch_next = num_mismatch;
        if (cmp_valid) begin
            if (num_read != CNT_MAX)
                read_next = num_read + CNT_ONE;
            if ((fifo_data_out != exp_data) && (num_mismatch != CNT_MAX))
                mismatch_next = num_mismatch + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            issue_idx    <= '0;
            cmp_valid    <= 1'b0;
            exp_count_q  <= '0;
            num_read     <= '0;
            num_mismatch <= '0;
            pass         <= 1'b0;
            count_short  <= 1'b0;
        end else begin
            cmp_valid <= fifo_deq;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_DRAIN;
                        issue_idx    <= '0;
                        num_read     <= '0;
                        num_mismatch <= '0;
                        pass         <= 1'b0;
                        count_short  <= 1'b0;
                        exp_count_q  <= expected_count;
                    end
                end
                ST_DRAIN: begin
                    num_read     <= read_next;
                    num_mismatch <= mismatch_next;
                    if (fifo_deq) begin
                        issue_idx <= issue_idx + IDX_ONE;
                    end else begin
                        state       <= ST_DONE;
                        pass        <= (read_next >= exp_count_q) && (mismatch_next == '0);
                        count_short <= (read_next < exp_count_q);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_checker.sv
// tb/tb_fifo_drain_checker.sv - table-driven and randomized bench for fifo_drain_checker
module tb_fifo_drain_checker;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int CW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] expected_count;
    logic          fifo_deq;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_empty;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          busy, done, pass, count_short;
    logic [CW-1:0] num_read, num_mismatch;

    logic [DW-1:0] q[$];
    logic [DW-1:0] loaded[$];
    logic [DW-1:0] exp_mem [DEPTH];
    int            n_pass = 0;
    int            n_total = 0;

    typedef struct {
        int          n;
        logic [7:0]  data [3];
        logic [7:0]  expd [3];
        int          ecnt;
        int          e_read;
        int          e_mm;
        bit          e_pass;
        bit          e_short;
        int          e_done;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    fifo_drain_checker #(.DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .expected_count(expected_count),
        .fifo_deq(fifo_deq), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
        .exp_addr(exp_addr), .exp_data(exp_data), .busy(busy), .done(done), .pass(pass),
        .count_short(count_short), .num_read(num_read), .num_mismatch(num_mismatch)
    );

    // FIFO with registered empty flag and a synchronous expected memory
    always @(posedge clk) begin
        if (fifo_deq && q.size() > 0) fifo_data_out <= q.pop_front();
        fifo_empty <= (q.size() == 0);
        exp_data   <= exp_mem[exp_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    function automatic void model(input int ecnt, output int r, output int mm,
                                  output bit p, output bit s);
        r  = (loaded.size() < DEPTH) ? loaded.size() : DEPTH;
        mm = 0;
        for (int i = 0; i < r; i++) if (loaded[i] != exp_mem[i]) mm++;
        p = (r >= ecnt) && (mm == 0);
        s = (r < ecnt);
    endfunction

    task automatic run_drain(input string tag, input int ecnt, input bit poke,
                             input int e_read, input int e_mm, input bit e_pass,
                             input bit e_short, input int e_done, input int e_left);
        int deqs = 0;
        int done_cyc = -1;
        bit addr_ok = 1'b1;
        bit got_done = 1'b0;
        @(negedge clk);
        expected_count = ecnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (fifo_deq) begin
                if (exp_addr != AW'(deqs)) addr_ok = 1'b0;
                deqs++;
            end
            if (done) begin
                done_cyc = cyc;
                got_done = 1'b1;
                check({tag, "_num_read"}, 64'(num_read), 64'(e_read));
                check({tag, "_num_mismatch"}, 64'(num_mismatch), 64'(e_mm));
                check({tag, "_pass"}, 64'(pass), 64'(e_pass));
                check({tag, "_count_short"}, 64'(count_short), 64'(e_short));
                start = poke;
                break;
            end
            start = poke && (cyc == 2);
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(got_done), 64'(1));
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(e_done));
        check({tag, "_deq_count"}, 64'(deqs), 64'(e_read));
        check({tag, "_addr_order"}, 64'(addr_ok), 64'(1));
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle_after"}, 64'({busy, done}), 64'(0));
        check({tag, "_pass_held"}, 64'(pass), 64'(e_pass));
        check({tag, "_left"}, 64'(q.size()), 64'(e_left));
    endtask

    task automatic run_model(input string tag, input int ecnt, input bit poke);
        int r, mm;
        bit p, s;
        model(ecnt, r, mm, p, s);
        run_drain(tag, ecnt, poke, r, mm, p, s, r + 2, loaded.size() - r);
    endtask

    initial begin
        vecs[0] = '{3, '{8'd3, 8'd7, 8'd9}, '{8'd3, 8'd7, 8'd9}, 3, 3, 0, 1'b1, 1'b0, 5};
        vecs[1] = '{3, '{8'd3, 8'd8, 8'd9}, '{8'd3, 8'd7, 8'd9}, 3, 3, 1, 1'b0, 1'b0, 5};
        vecs[2] = '{2, '{8'd3, 8'd7, 8'd0}, '{8'd3, 8'd7, 8'd0}, 3, 2, 0, 1'b0, 1'b1, 4};
        vecs[3] = '{0, '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}, 0, 0, 0, 1'b1, 1'b0, 2};
        vecs[4] = '{0, '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}, 5, 0, 0, 1'b0, 1'b1, 2};

        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        fifo_data_out  = '0;
        exp_data       = '0;
        fifo_empty     = 1'b1;
        start          = 1'b0;
        expected_count = '0;
        reset          = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({fifo_deq, busy, done, pass, count_short}), 64'(0));
        check("reset_counters", 64'({num_read, num_mismatch}), 64'(0));
        check("reset_addr", 64'(exp_addr), 64'(0));
        reset = 1'b1;

        for (int v = 0; v < 5; v++) begin
            q.delete();
            loaded.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                q.push_back(vecs[v].data[i]);
                loaded.push_back(vecs[v].data[i]);
            end
            for (int i = 0; i < 3; i++) exp_mem[i] = vecs[v].expd[i];
            run_drain($sformatf("vec%0d", v), vecs[v].ecnt, 1'b0, vecs[v].e_read,
                      vecs[v].e_mm, vecs[v].e_pass, vecs[v].e_short, vecs[v].e_done, 0);
        end

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(0, 20);
            q.delete();
            loaded.delete();
            for (int i = 0; i < n; i++) begin
                logic [DW-1:0] d;
                d = DW'($urandom);
                q.push_back(d);
                loaded.push_back(d);
                exp_mem[i] = ($urandom_range(0, 3) == 0) ? d ^ DW'($urandom_range(1, 255)) : d;
            end
            run_model($sformatf("rand%0d", t), $urandom_range(0, 22), t[0]);
        end

        q.delete();
        loaded.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            q.push_back(DW'(i));
            loaded.push_back(DW'(i));
            if (i < DEPTH) exp_mem[i] = DW'(i);
        end
        run_drain("depth", DEPTH, 1'b0, DEPTH, 0, 1'b1, 1'b0, DEPTH + 2, 1);

        q.delete();
        for (int i = 0; i < 6; i++) begin
            q.push_back(DW'(10 + i));
            exp_mem[i] = DW'(10 + i);
        end
        @(negedge clk);
        expected_count = 6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_deq_before_reset", 64'(fifo_deq), 64'(1));
        reset = 1'b0;
        #1;
        check("mid_reset_deq", 64'(fifo_deq), 64'(0));
        check("mid_reset_outputs", 64'({busy, done, pass, count_short, exp_addr}), 64'(0));
        check("mid_reset_counters", 64'({num_read, num_mismatch}), 64'(0));
        check("mid_reset_left", 64'(q.size()), 64'(4));
        @(negedge clk);
        reset = 1'b1;
        loaded.delete();
        for (int i = 0; i < q.size(); i++) begin
            loaded.push_back(q[i]);
            exp_mem[i] = q[i];
        end
        run_drain("after_reset", 4, 1'b1, 4, 0, 1'b1, 1'b0, 6, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
